sha256_msg_padder: RTL and testbench



---
 rtl/sha256_msg_padder.sv | 197 +++++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
// -----------------------------------------------------------------------------
// sha256_msg_padder
//
// Upstream feeder for a SHA-256 hash core. Takes a message as a byte stream,
// packs it big-endian into 512-bit blocks and applies the standard SHA-256
// padding: a 0x80 marker byte, zero fill, then the 64-bit message bit-length
// in the last eight bytes of the final block. Blocks are presented one at a
// time. blk_first tells the core to load the IV. blk_last tells it that the
// digest is final.
//
// Ports:
//   clk        in   1    clock
//   reset      in   1    asynchronous, active-high reset
//   in_data    in   8    message byte
//   in_valid   in   1    in_data/in_keep/in_last valid
//   in_keep    in   1    1 = in_data is a real byte. 0 = no byte. keep=0 is
//                        only meaningful with in_last (zero-length message).
//   in_last    in   1    final beat of the message
//   in_ready   out  1    padder accepts a beat this cycle
//   blk_data   out  512  padded block. Byte 0 is at [511:504], byte 63 at [7:0].
//   blk_valid  out  1    blk_data valid
//   blk_ready  in   1    consumer accepts the block
//   blk_first  out  1    block is the first block of its message
//   blk_last   out  1    block is the final block (carries the length field)
// -----------------------------------------------------------------------------
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_keep,
    input  logic         in_last,
    output logic         in_ready,
    output logic [511:0] blk_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         blk_first,
    output logic         blk_last
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        OUT  = 2'd2,
        LEN  = 2'd3
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    // The block buffer doubles as the output register. It is only written in
    // FILL, PAD and LEN, so it stays stable for the whole of OUT.
    logic [511:0]       blk_reg;
    logic [5:0]         idx_reg;
    logic [LEN_W-1:0]   bitlen_reg;
    logic               first_pend_reg;
    logic               final_reg;
    logic               need_len_reg;
    // The last byte of the message landed in byte 63. The marker byte must
    // therefore start the next block.
    logic               wrap_reg;

    logic               accept;
    logic               idx_full;
    logic [5:0]         m_pos;
    logic               len_fits;
    logic [511:0]       pad_blk;

    // Gate ready with reset so that no beat appears accepted while reset is
    // held. State already sits in FILL during reset.
    assign in_ready  = (state_reg == FILL) && !reset;
    assign accept    = in_valid && in_ready;
    assign idx_full  = (idx_reg == 6'd63);

    assign blk_data  = blk_reg;
    assign blk_valid = (state_reg == OUT);
    assign blk_first = (state_reg == OUT) && first_pend_reg;
    assign blk_last  = (state_reg == OUT) && final_reg;

    // Pad image of the current buffer. Bytes before the marker are kept. The
    // marker is 0x80. Later bytes are zero, except that the length field
    // occupies bytes 56..63 whenever the marker leaves room for it.
    assign m_pos    = wrap_reg ? 6'd0 : idx_reg;
    assign len_fits = (m_pos <= 6'd55);

    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_pad
            if (gi >= 56) begin : g_len_byte
                assign pad_blk[8*(63-gi) +: 8] =
                    (m_pos >  6'(gi)) ? blk_reg[8*(63-gi) +: 8] :
                    (m_pos == 6'(gi)) ? 8'h80 :
                    len_fits          ? bitlen_reg[8*(63-gi) +: 8] :
                                        8'h00;
            end else begin : g_data_byte
                assign pad_blk[8*(63-gi) +: 8] =
                    (m_pos >  6'(gi)) ? blk_reg[8*(63-gi) +: 8] :
                    (m_pos == 6'(gi)) ? 8'h80 :
                                        8'h00;
            end
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FILL: begin
                if (accept) begin
                    if (in_last) begin
                        // A full final block goes out as plain data first.
                        state_next = (in_keep && idx_full) ? OUT : PAD;
                    end else if (in_keep && idx_full) begin
                        state_next = OUT;
                    end
                end
            end
            PAD: state_next = OUT;
            OUT: begin
                if (blk_ready) begin
                    if (final_reg)         state_next = FILL;
                    else if (need_len_reg) state_next = LEN;
                    else if (wrap_reg)     state_next = PAD;
                    else                   state_next = FILL;
                end
            end
            LEN: state_next = OUT;
            default: state_next = FILL;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_reg        <= '0;
            idx_reg        <= '0;
            bitlen_reg     <= '0;
            first_pend_reg <= 1'b1;
            final_reg      <= 1'b0;
            need_len_reg   <= 1'b0;
            wrap_reg       <= 1'b0;
        end else begin
            case (state_reg)
                FILL: begin
                    if (accept && in_keep) begin
                        // Byte idx lives at bit offset 8*(63-idx). For a
                        // 6-bit idx, 63-idx equals ~idx.
                        blk_reg[{~idx_reg, 3'b000} +: 8] <= in_data;
                        idx_reg    <= idx_reg + 6'd1;
                        bitlen_reg <= bitlen_reg + LEN_W'(8);
                        if (in_last && idx_full) begin
                            wrap_reg <= 1'b1;
                        end
                    end
                end
                PAD: begin
                    blk_reg      <= pad_blk;
                    final_reg    <= len_fits;
                    need_len_reg <= !len_fits;
                    wrap_reg     <= 1'b0;
                end
                OUT: begin
                    if (blk_ready) begin
                        first_pend_reg <= 1'b0;
                        if (final_reg) begin
                            idx_reg        <= '0;
                            bitlen_reg     <= '0;
                            first_pend_reg <= 1'b1;
                            final_reg      <= 1'b0;
                        end else if (!need_len_reg) begin
                            // Covers both the plain data block and the wrap
                            // case. The wrapped pad block starts at byte 0.
                            idx_reg <= '0;
                        end
                    end
                end
                LEN: begin
                    blk_reg      <= {{(512-LEN_W){1'b0}}, bitlen_reg};
                    final_reg    <= 1'b1;
                    need_len_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
module tb_sha256_msg_padder;

    logic         clk;
    logic         reset;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_keep;
    logic         in_last;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_first;
    logic         blk_last;

    int passed;
    int total;

    sha256_msg_padder #(.LEN_W(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_keep   (in_keep),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_first (blk_first),
        .blk_last  (blk_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one beat. Returns 1ns after the accepting edge with in_valid low.
    task automatic send_beat(input logic [7:0] d, input logic k, input logic l);
        int n;
        @(negedge clk);
        in_data  = d;
        in_keep  = k;
        in_last  = l;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            $display("FAIL beat_timeout: in_ready=%0b required 1 within 200 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_keep  = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait for a block, capture it and complete the handshake.
    task automatic get_block(output logic [511:0] d, output logic f, output logic l);
        int n;
        n = 0;
        @(negedge clk);
        while (!blk_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++;
            $display("FAIL blk_timeout: blk_valid=%0b required 1 within 300 cycles", blk_valid);
        end
        d = blk_data;
        f = blk_first;
        l = blk_last;
        $display("block: first=%0b last=%0b data=%h", f, l, d);
        blk_ready = 1'b1;
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_keep   = 1'b0;
        in_last   = 1'b0;
        in_data   = 8'h00;
        blk_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %0b required 0", in_ready); else passed++;
        total++; if (blk_valid !== 1'b0) $display("FAIL rst_blk_valid: got %0b required 0", blk_valid); else passed++;
        total++; if ({blk_first, blk_last} !== 2'b00) $display("FAIL rst_flags: got %b required 00", {blk_first, blk_last}); else passed++;
        total++; if (blk_data !== 512'b0) $display("FAIL rst_blk_data: got %h required 0", blk_data); else passed++;
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %0b required 1", in_ready); else passed++;
        $display("reset: done");
    endtask

    task automatic test_abc();
        logic [511:0] d;
        logic f, l;
        logic [511:0] exp_blk;
        exp_blk = {32'h61626380, 448'b0, 32'h00000018};
        send_beat(8'h61, 1'b1, 1'b0);
        send_beat(8'h62, 1'b1, 1'b0);
        send_beat(8'h63, 1'b1, 1'b1);
        // One cycle after the accepting edge: still in the pad cycle.
        total++; if (blk_valid !== 1'b0) $display("FAIL abc_latency_early: blk_valid=%0b required 0", blk_valid); else passed++;
        @(posedge clk);
        #1;
        total++; if (blk_valid !== 1'b1) $display("FAIL abc_latency: blk_valid=%0b required 1", blk_valid); else passed++;
        get_block(d, f, l);
        total++; if (d !== exp_blk) $display("FAIL abc_data: got %h required %h", d, exp_blk); else passed++;
        total++; if ({f, l} !== 2'b11) $display("FAIL abc_flags: got %b required 11", {f, l}); else passed++;
    endtask

    task automatic test_zero_len();
        logic [511:0] d;
        logic f, l;
        logic [511:0] exp_blk;
        exp_blk = {8'h80, 504'b0};
        send_beat(8'h00, 1'b0, 1'b1);
        get_block(d, f, l);
        total++; if (d !== exp_blk) $display("FAIL zero_data: got %h required %h", d, exp_blk); else passed++;
        total++; if ({f, l} !== 2'b11) $display("FAIL zero_flags: got %b required 11", {f, l}); else passed++;
    endtask

    task automatic test_55_bytes();
        logic [511:0] d;
        logic f, l;
        logic [511:0] exp_blk;
        exp_blk = {440'b0, 8'h80, 64'h1B8};
        for (int i = 0; i < 55; i++) send_beat(8'h00, 1'b1, (i == 54));
        get_block(d, f, l);
        total++; if (d !== exp_blk) $display("FAIL b55_data: got %h required %h", d, exp_blk); else passed++;
        total++; if ({f, l} !== 2'b11) $display("FAIL b55_flags: got %b required 11", {f, l}); else passed++;
    endtask

    task automatic test_56_bytes();
        logic [511:0] d;
        logic f, l;
        logic [511:0] exp1;
        logic [511:0] exp2;
        exp1 = {{56{8'hAA}}, 8'h80, 56'b0};
        exp2 = {448'b0, 64'h1C0};
        for (int i = 0; i < 56; i++) send_beat(8'hAA, 1'b1, (i == 55));
        get_block(d, f, l);
        total++; if (d !== exp1) $display("FAIL b56_blk1_data: got %h required %h", d, exp1); else passed++;
        total++; if ({f, l} !== 2'b10) $display("FAIL b56_blk1_flags: got %b required 10", {f, l}); else passed++;
        get_block(d, f, l);
        total++; if (d !== exp2) $display("FAIL b56_blk2_data: got %h required %h", d, exp2); else passed++;
        total++; if ({f, l} !== 2'b01) $display("FAIL b56_blk2_flags: got %b required 01", {f, l}); else passed++;
    endtask

    task automatic test_64_stall();
        logic [511:0] d;
        logic f, l;
        logic [511:0] exp1;
        logic [511:0] exp2;
        int n;
        int bad;
        exp1 = {64{8'h5C}};
        exp2 = {8'h80, 440'b0, 64'h200};
        for (int i = 0; i < 64; i++) send_beat(8'h5C, 1'b1, (i == 63));
        n = 0;
        @(negedge clk);
        while (!blk_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (blk_data !== exp1 || in_ready !== 1'b0 || blk_valid !== 1'b1) begin
                bad++;
                $display("FAIL stall_cycle%0d: data=%h in_ready=%0b blk_valid=%0b required data=%h in_ready=0 blk_valid=1",
                         c, blk_data, in_ready, blk_valid, exp1);
            end
        end
        total++; if (bad != 0) $display("FAIL stall_summary: got %0d bad cycles required 0", bad); else passed++;
        get_block(d, f, l);
        total++; if (d !== exp1) $display("FAIL b64_blk1_data: got %h required %h", d, exp1); else passed++;
        total++; if ({f, l} !== 2'b10) $display("FAIL b64_blk1_flags: got %b required 10", {f, l}); else passed++;
        get_block(d, f, l);
        total++; if (d !== exp2) $display("FAIL b64_blk2_data: got %h required %h", d, exp2); else passed++;
        total++; if ({f, l} !== 2'b01) $display("FAIL b64_blk2_flags: got %b required 01", {f, l}); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [511:0] d;
        logic f, l;
        logic [511:0] exp_blk;
        int seen;
        exp_blk = {32'h61626380, 448'b0, 32'h00000018};
        for (int i = 0; i < 20; i++) send_beat(8'hEE, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (in_ready !== 1'b0) $display("FAIL midrst_in_ready: got %0b required 0", in_ready); else passed++;
        reset = 1'b0;
        send_beat(8'h61, 1'b1, 1'b0);
        send_beat(8'h62, 1'b1, 1'b0);
        send_beat(8'h63, 1'b1, 1'b1);
        get_block(d, f, l);
        total++; if (d !== exp_blk) $display("FAIL midrst_data: got %h required %h", d, exp_blk); else passed++;
        total++; if ({f, l} !== 2'b11) $display("FAIL midrst_flags: got %b required 11", {f, l}); else passed++;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (blk_valid) seen++;
        end
        total++; if (seen != 0) $display("FAIL midrst_extra_block: got %0d valid cycles required 0", seen); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [511:0] d;
        logic f, l;
        logic [511:0] exp_blk;
        exp_blk = {8'h41, 8'h80, 432'b0, 64'h8};
        send_beat(8'h00, 1'b0, 1'b0);   // keep=0 without last: ignored
        send_beat(8'h41, 1'b1, 1'b1);
        get_block(d, f, l);
        total++; if (d !== exp_blk) $display("FAIL b2b_msg1_data: got %h required %h", d, exp_blk); else passed++;
        total++; if ({f, l} !== 2'b11) $display("FAIL b2b_msg1_flags: got %b required 11", {f, l}); else passed++;
        send_beat(8'h41, 1'b1, 1'b1);
        get_block(d, f, l);
        total++; if (d !== exp_blk) $display("FAIL b2b_msg2_data: got %h required %h", d, exp_blk); else passed++;
        total++; if ({f, l} !== 2'b11) $display("FAIL b2b_msg2_flags: got %b required 11", {f, l}); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_abc();
        test_zero_len();
        test_55_bytes();
        test_56_bytes();
        test_64_stall();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
